// File: rtl/multicycle_cu.sv
// multicycle_cu: FSM control unit sequencing RV32I instructions through FETCH/DECODE/EXEC/MEM/WB,
// with memory-ready handshake, wait timeout, illegal-opcode trap and retire pulse.
module multicycle_cu #(
    parameter int OPC_W        = 7,
    parameter int ENABLE_JALR  = 1,
    parameter int ILLEGAL_TRAP = 1,
    parameter int MAX_WAIT     = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       mem_out_sel,
    output logic             reg_write,
    output logic             branch,
    output logic             jump,
    output logic             retire,
    output logic             halted,
    output logic             bus_error
);
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [OPC_W-1:0] OP_LUI    = OPC_W'(7'b0110111);
    localparam logic [OPC_W-1:0] OP_AUIPC  = OPC_W'(7'b0010111);
    localparam logic [OPC_W-1:0] OP_JAL    = OPC_W'(7'b1101111);
    localparam logic [OPC_W-1:0] OP_JALR   = OPC_W'(7'b1100111);
    localparam logic [OPC_W-1:0] OP_IMM    = OPC_W'(7'b0010011);
    localparam logic [OPC_W-1:0] OP_OP     = OPC_W'(7'b0110011);
    localparam logic [OPC_W-1:0] OP_LOAD   = OPC_W'(7'b0000011);
    localparam logic [OPC_W-1:0] OP_STORE  = OPC_W'(7'b0100011);
    localparam logic [OPC_W-1:0] OP_BRANCH = OPC_W'(7'b1100011);

    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;

    state_t           state_q, state_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             bus_error_q, bus_error_d;

    function automatic logic legal(input logic [OPC_W-1:0] o);
        return o == OP_LUI || o == OP_AUIPC || o == OP_JAL || o == OP_IMM || o == OP_OP ||
               o == OP_LOAD || o == OP_STORE || o == OP_BRANCH || (ENABLE_JALR != 0 && o == OP_JALR);
    endfunction

    logic is_load, is_store, is_link, legal_in, waiting, timeout;
    assign is_load  = opcode_q == OP_LOAD;
    assign is_store = opcode_q == OP_STORE;
    assign is_link  = opcode_q == OP_JAL || opcode_q == OP_JALR;
    assign legal_in = legal(opcode);
    assign waiting  = (state_q == FETCH || state_q == MEM) && !mem_ready;
    assign timeout  = MAX_WAIT > 0 && waiting && wait_cnt_q == CW'(MAX_WAIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : timeout ? HALT : FETCH;
            DECODE:  state_d = legal_in ? EXEC : (ILLEGAL_TRAP != 0) ? HALT : FETCH;
            EXEC:    state_d = opcode_q == OP_BRANCH ? FETCH : (is_load || is_store) ? MEM : WB;
            MEM:     state_d = mem_ready ? (is_load ? WB : FETCH) : timeout ? HALT : MEM;
            WB:      state_d = FETCH;
            default: state_d = HALT;
        endcase
        opcode_d    = state_q == DECODE ? opcode : opcode_q;
        wait_cnt_d  = state_d != state_q ? '0 : waiting ? wait_cnt_q + CW'(1) : wait_cnt_q;
        bus_error_d = bus_error_q | timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            opcode_q    <= '0;
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Strobes are combinational so that a reset cycle suppresses them immediately.
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_op      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 1'b0;
        mem_out_sel = 2'b00;
        reg_write   = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        retire      = 1'b0;
        halted      = 1'b0;
        bus_error   = 1'b0;
        if (!rst) begin
            bus_error = bus_error_q;
            case (state_q)
                FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                DECODE: retire = !legal_in && ILLEGAL_TRAP == 0;
                EXEC: begin
                    alu_op    = opcode_q == OP_LUI ? 2'b00 :
                                (opcode_q == OP_OP || opcode_q == OP_IMM) ? 2'b11 :
                                opcode_q == OP_BRANCH ? 2'b01 : 2'b10;
                    alu_src_a = opcode_q == OP_AUIPC || opcode_q == OP_JAL;
                    alu_src_b = !(opcode_q == OP_LUI || opcode_q == OP_OP || opcode_q == OP_BRANCH);
                    branch    = opcode_q == OP_BRANCH;
                    retire    = opcode_q == OP_BRANCH;
                end
                MEM: begin
                    iord      = 1'b1;
                    mem_read  = is_load;
                    mem_write = is_store;
                    retire    = is_store && mem_ready;
                end
                WB: begin
                    reg_write   = 1'b1;
                    retire      = 1'b1;
                    jump        = is_link;
                    pc_write    = is_link;
                    mem_out_sel = opcode_q == OP_LUI ? 2'b10 : is_load ? 2'b01 : is_link ? 2'b11 : 2'b00;
                end
                HALT:    halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end
endmodule
